hwpe_stream_lifo: RTL and testbench

- Single-clock last-in/first-out buffer for HWPE-Stream streams.
- Accepts beats on a sink port and returns them on a source port in reverse arrival order.
- Typical uses: reversing a tile or row, and unwinding streams inside HWPE datapaths.
- Same handshake discipline and flag set as the team's stream FIFO. No combinational path from `push_i` to `pop_o` or back; every beat is stored for at least one cycle.

---
 rtl/hwpe_stream_lifo.sv | 122 ++++++++++++
 tb/tb_hwpe_stream_lifo.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_lifo.sv
// rtl/hwpe_stream_lifo.sv - single-clock last-in/first-out buffer for HWPE-Stream beats

package hwpe_stream_lifo_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } flags_fifo_t;

endpackage

module hwpe_stream_lifo
  import hwpe_stream_lifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned LIFO_DEPTH = 8,
  localparam int unsigned STRB_WIDTH = (DATA_WIDTH + 7) / 8,
  localparam int unsigned LVL_WIDTH  = $clog2(LIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // sink stream (push side)
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [STRB_WIDTH-1:0] push_strb_i,
  // source stream (pop side, top of stack)
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [STRB_WIDTH-1:0] pop_strb_o,
  // status
  output flags_fifo_t           flags_o,
  output logic [LVL_WIDTH-1:0]  level_o
);

  localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + STRB_WIDTH;
  localparam int unsigned IDX_WIDTH   = $clog2(LIFO_DEPTH);

  localparam logic [LVL_WIDTH-1:0] LVL_FULL   = LVL_WIDTH'(LIFO_DEPTH);
  localparam logic [LVL_WIDTH-1:0] LVL_AFULL  = LVL_WIDTH'(LIFO_DEPTH - 1);
  localparam logic [LVL_WIDTH-1:0] LVL_ONE    = LVL_WIDTH'(1);

  logic [LVL_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ENTRY_WIDTH-1:0] mem_q [LIFO_DEPTH];

  logic                   push_ready;
  logic                   pop_valid;
  logic                   do_push;
  logic                   do_pop;
  logic [IDX_WIDTH-1:0]   top_idx;
  logic [IDX_WIDTH-1:0]   wr_idx;
  logic                   wr_en;
  logic [ENTRY_WIDTH-1:0] wr_entry;
  logic [ENTRY_WIDTH-1:0] top_entry;

  // Handshakes come only from the registered count, so push and pop never
  // see each other combinationally; a full stack refuses a push even if a
  // pop frees a slot in the same cycle.
  assign push_ready = (cnt_q != LVL_FULL);
  assign pop_valid  = (cnt_q != '0);
  assign do_push    = push_valid_i & push_ready;
  assign do_pop     = pop_ready_i & pop_valid;

  // Top index is forced to 0 while empty so the read never leaves the array
  // for depths that are not a power of two.
  assign top_idx   = pop_valid ? IDX_WIDTH'(cnt_q - LVL_ONE) : '0;
  assign top_entry = mem_q[top_idx];
  assign wr_entry  = {push_data_i, push_strb_i};

  // Next count and the single write port: plain push appends above the top,
  // simultaneous push+pop overwrites the top slot in place.
  always_comb begin
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = IDX_WIDTH'(cnt_q);
    unique case ({do_push, do_pop})
      2'b10: begin
        wr_en  = 1'b1;
        wr_idx = IDX_WIDTH'(cnt_q);
        cnt_d  = cnt_q + LVL_ONE;
      end
      2'b01: begin
        cnt_d  = cnt_q - LVL_ONE;
      end
      2'b11: begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
      default: begin
        cnt_d  = cnt_q;
      end
    endcase
  end

  // Count and storage; reset clears every entry and wins over any transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      if (wr_en) begin
        mem_q[wr_idx] <= wr_entry;
      end
    end
  end

  assign push_ready_o = push_ready;
  assign pop_valid_o  = pop_valid;
  assign pop_data_o   = pop_valid ? top_entry[ENTRY_WIDTH-1:STRB_WIDTH] : '0;
  assign pop_strb_o   = pop_valid ? top_entry[STRB_WIDTH-1:0] : '0;

  assign flags_o.empty        = (cnt_q == '0);
  assign flags_o.full         = (cnt_q == LVL_FULL);
  assign flags_o.almost_empty = (cnt_q == LVL_ONE);
  assign flags_o.almost_full  = (cnt_q == LVL_AFULL);
  assign level_o              = cnt_q;

endmodule

// File: tb/tb_hwpe_stream_lifo.sv
// tb/tb_hwpe_stream_lifo.sv - directed and random checks for hwpe_stream_lifo

module tb_hwpe_stream_lifo;
  import hwpe_stream_lifo_pkg::*;

  logic        clk;
  logic        rst;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_data;
  logic [3:0]  push_strb;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_data;
  logic [3:0]  pop_strb;
  flags_fifo_t flags;
  logic [3:0]  level;

  int checks   = 0;
  int failures = 0;

  hwpe_stream_lifo #(
    .DATA_WIDTH (32),
    .LIFO_DEPTH (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .push_data_i  (push_data),
    .push_strb_i  (push_strb),
    .pop_valid_o  (pop_valid),
    .pop_ready_i  (pop_ready),
    .pop_data_o   (pop_data),
    .pop_strb_o   (pop_strb),
    .flags_o      (flags),
    .level_o      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] sb(input logic [31:0] d);
    return d[3:0] ^ 4'h5;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [31:0] d);
    push_valid = v;
    push_data  = d;
    push_strb  = sb(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_push(1'b0, 32'h0);
    pop_ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_push(1'b1, 32'h77);
    pop_ready = 1'b1;
    cycle();
    cycle();
    checks++;
    if ({level, push_ready, pop_valid, pop_data, pop_strb, flags} !== {4'd0, 1'b1, 1'b0, 32'h0, 4'h0, 4'b1000}) begin
      failures++;
      $display("FAIL reset_during lvl=%0d rdy=%b vld=%b data=%h strb=%h flags=%b exp lvl=0 rdy=1 vld=0 data=0 strb=0 flags=1000",
               level, push_ready, pop_valid, pop_data, pop_strb, flags);
    end
    rst = 1'b0;
    set_push(1'b0, 32'h0);
    pop_ready = 1'b0;
    cycle();
    checks++;
    if ({level, push_ready, pop_valid, pop_data, pop_strb, flags} !== {4'd0, 1'b1, 1'b0, 32'h0, 4'h0, 4'b1000}) begin
      failures++;
      $display("FAIL reset_after lvl=%0d rdy=%b vld=%b data=%h flags=%b exp lvl=0 rdy=1 vld=0 data=0 flags=1000",
               level, push_ready, pop_valid, pop_data, flags);
    end
  endtask

  task automatic test_fill_drain();
    pop_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      set_push(1'b1, 32'(i));
      cycle();
    end
    set_push(1'b0, 32'h0);
    checks++;
    if ({level, push_ready, pop_valid, pop_data, pop_strb, flags} !== {4'd8, 1'b0, 1'b1, 32'd8, sb(32'd8), 4'b0100}) begin
      failures++;
      $display("FAIL fill_full lvl=%0d rdy=%b vld=%b data=%h flags=%b exp lvl=8 rdy=0 vld=1 data=8 flags=0100",
               level, push_ready, pop_valid, pop_data, flags);
    end
    pop_ready = 1'b1;
    for (int i = 8; i >= 1; i--) begin
      checks++;
      if ({level, pop_valid, pop_data, pop_strb, flags} !==
          {4'(i), 1'b1, 32'(i), sb(32'(i)), 1'b0, i == 8, i == 1, i == 7}) begin
        failures++;
        $display("FAIL drain_%0d lvl=%0d vld=%b data=%h strb=%h flags=%b exp lvl=%0d data=%h",
                 i, level, pop_valid, pop_data, pop_strb, flags, i, i);
      end
      cycle();
    end
    checks++;
    if ({level, pop_valid, pop_data, pop_strb, flags} !== {4'd0, 1'b0, 32'h0, 4'h0, 4'b1000}) begin
      failures++;
      $display("FAIL drain_empty lvl=%0d vld=%b data=%h flags=%b exp lvl=0 vld=0 data=0 flags=1000",
               level, pop_valid, pop_data, flags);
    end
    pop_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      set_push(1'b1, 32'(i));
      cycle();
    end
    set_push(1'b1, 32'hAA);
    pop_ready = 1'b1;
    checks++;
    if ({push_ready, pop_data} !== {1'b0, 32'd8}) begin
      failures++;
      $display("FAIL bp_full_pop rdy=%b data=%h exp rdy=0 data=8", push_ready, pop_data);
    end
    cycle();
    pop_ready = 1'b0;
    checks++;
    if ({level, push_ready, pop_data} !== {4'd7, 1'b1, 32'd7}) begin
      failures++;
      $display("FAIL bp_refused lvl=%0d rdy=%b data=%h exp lvl=7 rdy=1 data=7", level, push_ready, pop_data);
    end
    cycle();
    set_push(1'b0, 32'h0);
    checks++;
    if ({level, pop_data, pop_strb, flags.full} !== {4'd8, 32'hAA, sb(32'hAA), 1'b1}) begin
      failures++;
      $display("FAIL bp_accepted lvl=%0d data=%h strb=%h full=%b exp lvl=8 data=aa strb=%h full=1",
               level, pop_data, pop_strb, flags.full, sb(32'hAA));
    end
  endtask

  task automatic test_replace();
    do_reset();
    set_push(1'b1, 32'h10);
    cycle();
    set_push(1'b1, 32'h20);
    cycle();
    set_push(1'b1, 32'h30);
    pop_ready = 1'b1;
    checks++;
    if (pop_data !== 32'h20) begin
      failures++;
      $display("FAIL replace_popped got=%h exp=20", pop_data);
    end
    cycle();
    set_push(1'b0, 32'h0);
    checks++;
    if ({level, pop_data, pop_strb} !== {4'd2, 32'h30, sb(32'h30)}) begin
      failures++;
      $display("FAIL replace_top lvl=%0d data=%h exp lvl=2 data=30", level, pop_data);
    end
    cycle();
    checks++;
    if ({level, pop_data, flags.almost_empty} !== {4'd1, 32'h10, 1'b1}) begin
      failures++;
      $display("FAIL replace_bottom lvl=%0d data=%h ae=%b exp lvl=1 data=10 ae=1", level, pop_data, flags.almost_empty);
    end
    cycle();
    pop_ready = 1'b0;
    checks++;
    if ({level, pop_valid} !== {4'd0, 1'b0}) begin
      failures++;
      $display("FAIL replace_empty lvl=%0d vld=%b exp lvl=0 vld=0", level, pop_valid);
    end
  endtask

  task automatic test_empty_pop();
    do_reset();
    pop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({level, pop_valid, pop_data, pop_strb, flags.empty} !== {4'd0, 1'b0, 32'h0, 4'h0, 1'b1}) begin
        failures++;
        $display("FAIL empty_pop_%0d lvl=%0d vld=%b data=%h exp lvl=0 vld=0 data=0", i, level, pop_valid, pop_data);
      end
    end
    pop_ready = 1'b0;
    set_push(1'b1, 32'h5);
    checks++;
    if (pop_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_latency vld=%b exp=0", pop_valid);
    end
    cycle();
    set_push(1'b0, 32'h0);
    checks++;
    if ({pop_valid, pop_data, pop_strb} !== {1'b1, 32'h5, sb(32'h5)}) begin
      failures++;
      $display("FAIL empty_then_push vld=%b data=%h exp vld=1 data=5", pop_valid, pop_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h41 + 32'(i));
      cycle();
    end
    set_push(1'b1, 32'h99);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_push(1'b0, 32'h0);
    checks++;
    if ({level, pop_valid, pop_data, flags} !== {4'd0, 1'b0, 32'h0, 4'b1000}) begin
      failures++;
      $display("FAIL reset_mid lvl=%0d vld=%b data=%h flags=%b exp lvl=0 vld=0 data=0 flags=1000",
               level, pop_valid, pop_data, flags);
    end
    cycle();
    checks++;
    if ({level, pop_valid} !== {4'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_hold lvl=%0d vld=%b exp lvl=0 vld=0", level, pop_valid);
    end
  endtask

  task automatic test_random_stress();
    logic [35:0] stk[$];
    logic [35:0] top;
    logic [31:0] d;
    logic        pv, pr, dp, dq;
    int          sz;
    int          shown;
    shown = 0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      sz  = stk.size();
      top = (sz != 0) ? stk[sz-1] : 36'h0;
      checks++;
      if ({level, push_ready, pop_valid, pop_data, pop_strb, flags} !==
          {4'(sz), sz != 8, sz != 0, top, sz == 0, sz == 8, sz == 1, sz == 7}) begin
        failures++;
        if (shown < 10) begin
          shown++;
          $display("FAIL stress_c%0d lvl=%0d rdy=%b vld=%b data=%h strb=%h flags=%b exp lvl=%0d top=%h",
                   c, level, push_ready, pop_valid, pop_data, pop_strb, flags, sz, top);
        end
      end
      if ((c / 500) % 2 == 0) begin
        pv = ($urandom_range(0, 99) < 60);
        pr = ($urandom_range(0, 99) < 40);
      end else begin
        pv = ($urandom_range(0, 99) < 40);
        pr = ($urandom_range(0, 99) < 60);
      end
      d = $urandom;
      set_push(pv, d);
      pop_ready = pr;
      dp = pv && (sz != 8);
      dq = pr && (sz != 0);
      if (dq) void'(stk.pop_back());
      if (dp) stk.push_back({d, sb(d)});
      cycle();
    end
    set_push(1'b0, 32'h0);
    pop_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_push(1'b0, 32'h0);
    pop_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_replace();
    test_empty_pop();
    test_reset_mid();
    test_random_stress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
